// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: pops receiver bytes, folds E0/F0/E1 prefixes into key events, queues them.
// Define PS2_DEC_LOCKS_EN to track caps/num/scroll lock toggles on lock_state.
module ps2_scancode_decoder #(
  parameter int EVT_DEPTH = 4,
  parameter int EVT_AW    = 2
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  output logic       kbd_nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       proto_err,
  output logic [2:0] lock_state
);

  typedef enum logic [2:0] {ST_BASE, ST_E0, ST_F0, ST_E0F0, ST_PAUSE} state_t;

  state_t           r_state;
  logic [2:0]       r_pause_cnt;
  logic             r_nextdata_n;
  logic             r_proto_err;
  logic [EVT_AW:0]  r_wptr;
  logic [EVT_AW:0]  r_rptr;
  logic [9:0]       r_mem [EVT_DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_sample;
  logic             w_pop;
  logic             w_push;
  logic             w_err;
  logic [9:0]       w_entry;
  logic [9:0]       w_head;
  state_t           w_next_state;
  logic [2:0]       w_next_cnt;
  logic             w_is_prefix;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[EVT_AW] != r_rptr[EVT_AW]) &&
                    (r_wptr[EVT_AW-1:0] == r_rptr[EVT_AW-1:0]);
  // A low strobe means the receiver still shows the byte just taken, so that cycle never samples.
  assign w_sample = kbd_ready && r_nextdata_n && !w_full;
  assign w_pop    = !w_empty && evt_ready;

  assign w_is_prefix = (kbd_data == 8'hE0) || (kbd_data == 8'hF0) || (kbd_data == 8'hE1);

  // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_pause_cnt;
    w_push       = 1'b0;
    w_err        = 1'b0;
    w_entry      = '0;
    if (w_sample) begin
      if (r_state == ST_PAUSE) begin
        w_next_cnt = r_pause_cnt - 3'd1;
        if (r_pause_cnt == 3'd1) begin
          w_push       = 1'b1;
          w_entry      = {1'b0, 1'b0, 8'hE1};
          w_next_state = ST_BASE;
        end
      end else if (kbd_data == 8'h00 || kbd_data == 8'hFF) begin
        w_err        = 1'b1;
        w_next_state = ST_BASE;
      end else begin
        case (r_state)
          ST_BASE: begin
            if (kbd_data == 8'hE0) begin
              w_next_state = ST_E0;
            end else if (kbd_data == 8'hF0) begin
              w_next_state = ST_F0;
            end else if (kbd_data == 8'hE1) begin
              w_next_state = ST_PAUSE;
              w_next_cnt   = 3'd7;
            end else begin
              w_push  = 1'b1;
              w_entry = {1'b0, 1'b0, kbd_data};
            end
          end
          ST_E0: begin
            if (kbd_data == 8'hF0) begin
              w_next_state = ST_E0F0;
            end else if (w_is_prefix) begin
              w_err        = 1'b1;
              w_next_state = ST_BASE;
            end else begin
              w_push       = 1'b1;
              w_entry      = {1'b1, 1'b0, kbd_data};
              w_next_state = ST_BASE;
            end
          end
          ST_F0, ST_E0F0: begin
            w_next_state = ST_BASE;
            if (w_is_prefix) begin
              w_err = 1'b1;
            end else begin
              w_push  = 1'b1;
              w_entry = {r_state == ST_E0F0, 1'b1, kbd_data};
            end
          end
          default: w_next_state = ST_BASE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= ST_BASE;
      r_pause_cnt  <= 3'd0;
      r_nextdata_n <= 1'b1;
      r_proto_err  <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
    end else begin
      r_state      <= w_next_state;
      r_pause_cnt  <= w_next_cnt;
      r_nextdata_n <= !w_sample;
      r_proto_err  <= w_err;
      r_wptr       <= r_wptr + (EVT_AW+1)'(w_push);
      r_rptr       <= r_rptr + (EVT_AW+1)'(w_pop);
    end
  end

  // NOTE: the event storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[EVT_AW-1:0]] <= w_entry;
  end

  assign w_head         = w_empty ? 10'd0 : r_mem[r_rptr[EVT_AW-1:0]];
  assign evt_valid      = !w_empty;
  assign evt_code       = w_head[7:0];
  assign evt_break      = w_head[8];
  assign evt_ext        = w_head[9];
  assign kbd_nextdata_n = r_nextdata_n;
  assign proto_err      = r_proto_err;

`ifdef PS2_DEC_LOCKS_EN
  logic [2:0] r_lock;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_lock <= 3'b000;
    end else if (w_push && w_entry[9:8] == 2'b00) begin
      if (w_entry[7:0] == 8'h58) r_lock[0] <= !r_lock[0];
      if (w_entry[7:0] == 8'h77) r_lock[1] <= !r_lock[1];
      if (w_entry[7:0] == 8'h7E) r_lock[2] <= !r_lock[2];
    end
  end

  assign lock_state = r_lock;
`else
  assign lock_state = 3'b000;
`endif

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard receiver.
- Pops raw scan-code bytes from the receiver's byte FIFO using its ready / nextdata_n handshake.
- Parses Set-2 prefixes (E0 extended, F0 break, E1 pause sequence) and pushes one key event per complete sequence into a small event FIFO.
- The event FIFO is drained by the keyboard bus adapter or CPU-side logic via a valid/ready port.

Parameters:
- EVT_DEPTH, 4: event FIFO entries; power of two, minimum 2.
- EVT_AW, 2: log2(EVT_DEPTH); pointer width is EVT_AW+1.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- kbd_data  in  8  scan-code byte from receiver; valid while kbd_ready=1
- kbd_ready  in  1  receiver FIFO non-empty
- kbd_nextdata_n  out  1  active-low pop strobe to receiver; registered
- evt_valid  out  1  event FIFO non-empty
- evt_ready  in  1  consumer accepts head event
- evt_code  out  8  key code of head event
- evt_break  out  1  head event is a key release
- evt_ext  out  1  head event had E0 prefix
- proto_err  out  1  one-cycle pulse on a malformed sequence or keyboard error byte
- lock_state  out  3  {scroll, num, caps} lock flags (see Optional Feature)

Behaviour:
- Reset: asynchronous on clrn=0. Values held in reset:
  - kbd_nextdata_n=1, proto_err=0, lock_state=0.
  - Event FIFO empty, so evt_valid=0.
  - Parser in ST_BASE, pause counter 0.
  - evt_code/evt_break/evt_ext = 0 while empty.
- Pop handshake:
  - Sample cycle: kbd_ready=1 AND kbd_nextdata_n=1 AND pop_gap=0 AND event FIFO not full. Use the full count; ignore any same-cycle evt pop.
  - On the sample-cycle edge the byte is consumed by the parser and kbd_nextdata_n is registered to 0.
  - kbd_nextdata_n stays 0 for exactly one cycle, then returns to 1.
  - pop_gap: the cycle in which kbd_nextdata_n=0 is never a sample cycle (the receiver still shows the old byte).
  - The earliest next sample is the cycle after the strobe, giving a maximum rate of one byte per 2 cycles.
- Parser states: ST_BASE, ST_E0, ST_F0, ST_E0F0, ST_PAUSE. Transitions, for byte b in a sample cycle:
  - Any state, b=0x00 or b=0xFF: proto_err pulse, go to ST_BASE, no event. Exception: in ST_PAUSE these bytes count as normal pause bytes.
  - ST_BASE:
    - E0 -> ST_E0.
    - F0 -> ST_F0.
    - E1 -> ST_PAUSE with counter=7.
    - Any other byte: push {code=b, break=0, ext=0}, stay in ST_BASE.
  - ST_E0:
    - F0 -> ST_E0F0.
    - E0 or E1: proto_err, go to ST_BASE.
    - Other: push {b, 0, 1}, go to ST_BASE.
  - ST_F0:
    - E0, F0 or E1: proto_err, go to ST_BASE.
    - Other: push {b, 1, 0}, go to ST_BASE.
  - ST_E0F0:
    - E0, F0 or E1: proto_err, go to ST_BASE.
    - Other: push {b, 1, 1}, go to ST_BASE.
  - ST_PAUSE:
    - Each byte decrements the counter; byte contents are ignored.
    - When the counter reaches 0: push {0xE1, 0, 0}, go to ST_BASE.
- Latency: the push happens on the sample-cycle edge, so evt_valid rises the next cycle if the FIFO was empty.
- Event FIFO:
  - Entry = {ext, break, code}, 10 bits.
  - Head is shown combinationally on evt_* outputs.
  - Pop when evt_valid & evt_ready.
  - Push and pop in the same cycle are both honoured.
  - Pointers wrap modulo 2*EVT_DEPTH; full = MSBs differ and low bits equal.
  - Overflow cannot occur because sampling is gated on not-full. Bytes back up in the receiver FIFO instead.
- evt_ready while empty: ignored.
- Reset mid-sequence (e.g. after E0) discards the partial sequence.

Optional Feature:
- Macro PS2_DEC_LOCKS_EN.
- Defined: lock_state registers toggle on the edge the corresponding make event is pushed:
  - caps (bit0) on {0x58, make, non-ext}.
  - num (bit1) on {0x77, make, non-ext}. The pause pseudo-event 0xE1 does not toggle it.
  - scroll (bit2) on {0x7E, make, non-ext}.
  - Break events never toggle.
  - Lock toggling is independent of the consumer.
- Undefined: lock_state tied to 3'b000 and no lock registers exist.

Test Plan:
- Bytes 0x1C, F0, 1C with evt_ready=1 -> events {1C,0,0} then {1C,1,0}. kbd_nextdata_n low exactly 3 single cycles, never in consecutive cycles.
- E0, 75, E0, F0, 75 -> events {75,0,1} and {75,1,1}; no proto_err.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,0,0}, pushed after the 8th byte; num lock unchanged.
- evt_ready=0 with 6 make codes queued -> 4 events held, evt_valid=1. kbd_nextdata_n stays 1 with kbd_ready=1 after the 4th. Raising evt_ready delivers all 6 in order.
- F0 then E0, and separately byte 0xFF -> one proto_err pulse each, no event. Following 0x1C yields {1C,0,0}.
- With PS2_DEC_LOCKS_EN: 58, F0 58, 58 -> lock_state 001 then 000. clrn pulse low mid-E0 -> all outputs reset immediately; next 0x1C yields {1C,0,0}.
